// File: rtl/cmask_range_encoder.sv
// cmask_range_encoder
// Turns a crossbar select mask into the ascending list of inclusive
// (C_start, C_end) runs of set bits. The mask is scanned CHUNK_WIDTH bits
// per cycle; a run that crosses a chunk boundary is still emitted once.
// Optional feature macro: CMASK_ENC_COUNT_EN adds the range_count port and
// its counter (runs emitted for the current / last mask).
module cmask_range_encoder #(
  parameter int NUM_CROSSBAR = 1024,
  parameter int SRC_SIZE     = 10,
  parameter int CHUNK_WIDTH  = 64
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NUM_CROSSBAR-1:0] mask_in,
  input  logic                    mask_valid,
  output logic                    mask_ready,
  output logic [SRC_SIZE-1:0]     C_start,
  output logic [SRC_SIZE-1:0]     C_end,
  output logic                    range_valid,
  input  logic                    range_ready,
`ifdef CMASK_ENC_COUNT_EN
  output logic [SRC_SIZE:0]       range_count,
`endif
  output logic                    done
);

  localparam int CHUNK_BITS = $clog2(CHUNK_WIDTH);
  localparam int NUM_CHUNKS = NUM_CROSSBAR / CHUNK_WIDTH;
  localparam int CIDX_W     = SRC_SIZE + 1 - CHUNK_BITS;

  localparam logic [SRC_SIZE:0]   PTR_END  = (SRC_SIZE+1)'(NUM_CROSSBAR);
  localparam logic [SRC_SIZE:0]   PTR_LAST = (SRC_SIZE+1)'(NUM_CROSSBAR - 1);
  localparam logic [SRC_SIZE:0]   PTR_ONE  = (SRC_SIZE+1)'(1);
  localparam logic [SRC_SIZE-1:0] IDX_ONE  = SRC_SIZE'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  r_state;
  logic [NUM_CROSSBAR-1:0] r_mask;
  logic [SRC_SIZE:0]       r_ptr;
  logic                    r_target;     // 1: seeking a run start, 0: seeking its end
  logic [SRC_SIZE-1:0]     r_start;
  logic [SRC_SIZE-1:0]     r_end;
  logic                    r_mask_ready;
  logic                    r_range_valid;
  logic                    r_done;

  logic [CIDX_W-1:0]       w_cidx;
  logic [CHUNK_BITS-1:0]   w_offset;
  logic [CHUNK_WIDTH-1:0]  w_chunk;
  logic [CHUNK_WIDTH-1:0]  w_cand;
  logic                    w_found;
  logic [CHUNK_BITS-1:0]   w_pos;
  logic [SRC_SIZE:0]       w_idx;
  logic [SRC_SIZE-1:0]     w_idx_m1;
  logic [SRC_SIZE:0]       w_chunk_end;
  logic                    w_last_chunk;
  logic                    w_accept;
  logic                    w_range_hs;
  logic                    w_emit_last;

  assign w_cidx       = r_ptr[SRC_SIZE:CHUNK_BITS];
  assign w_offset     = r_ptr[CHUNK_BITS-1:0];
  assign w_idx        = {w_cidx, w_pos};
  assign w_idx_m1     = w_idx[SRC_SIZE-1:0] - IDX_ONE;
  assign w_chunk_end  = {w_cidx, {CHUNK_BITS{1'b1}}};
  assign w_last_chunk = (w_chunk_end == PTR_LAST);
  assign w_accept     = (r_state == ST_IDLE) && mask_valid && r_mask_ready;
  assign w_range_hs   = (r_state == ST_EMIT) && range_ready;
  assign w_emit_last  = (r_ptr == PTR_END) || ({1'b0, r_end} == PTR_LAST);

  // Select the chunk that holds the scan pointer (one-hot OR mux).
  always_comb begin
    w_chunk = {CHUNK_WIDTH{1'b0}};
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      w_chunk = w_chunk | ((w_cidx == CIDX_W'(c)) ?
                           r_mask[c*CHUNK_WIDTH +: CHUNK_WIDTH] :
                           {CHUNK_WIDTH{1'b0}});
    end
  end

  // Candidates are bits equal to the target value at or above the pointer.
  always_comb begin
    w_cand  = (r_target ? w_chunk : ~w_chunk) & ({CHUNK_WIDTH{1'b1}} << w_offset);
    w_found = |w_cand;
  end

  // Lowest-index candidate within the window.
  always_comb begin
    w_pos = {CHUNK_BITS{1'b0}};
    for (int b = CHUNK_WIDTH - 1; b >= 0; b--) begin
      w_pos = w_cand[b] ? CHUNK_BITS'(b) : w_pos;
    end
  end

  // Control FSM with registered handshake outputs and scan datapath.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_mask        <= {NUM_CROSSBAR{1'b0}};
      r_ptr         <= {(SRC_SIZE+1){1'b0}};
      r_target      <= 1'b1;
      r_start       <= {SRC_SIZE{1'b0}};
      r_end         <= {SRC_SIZE{1'b0}};
      r_mask_ready  <= 1'b0;
      r_range_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_mask       <= mask_in;
            r_ptr        <= {(SRC_SIZE+1){1'b0}};
            r_target     <= 1'b1;
            r_mask_ready <= 1'b0;
            r_state      <= ST_SCAN;
          end else begin
            r_mask_ready <= 1'b1;
          end
        end

        ST_SCAN: begin
          if (w_found) begin
            if (r_target) begin
              r_start  <= w_idx[SRC_SIZE-1:0];
              r_ptr    <= w_idx + PTR_ONE;
              r_target <= 1'b0;
              if (w_idx == PTR_LAST) begin
                // A run starting on the final bit is also complete.
                r_end         <= w_idx[SRC_SIZE-1:0];
                r_range_valid <= 1'b1;
                r_state       <= ST_EMIT;
              end else begin
                r_state <= ST_SCAN;
              end
            end else begin
              r_end         <= w_idx_m1;
              r_ptr         <= w_idx;
              r_target      <= 1'b1;
              r_range_valid <= 1'b1;
              r_state       <= ST_EMIT;
            end
          end else begin
            r_ptr <= w_chunk_end + PTR_ONE;
            if (w_last_chunk) begin
              if (r_target) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                // Open run reaches the top of the mask.
                r_end         <= PTR_LAST[SRC_SIZE-1:0];
                r_range_valid <= 1'b1;
                r_state       <= ST_EMIT;
              end
            end else begin
              r_state <= ST_SCAN;
            end
          end
        end

        ST_EMIT: begin
          if (w_range_hs) begin
            r_range_valid <= 1'b0;
            if (w_emit_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_SCAN;
            end
          end else begin
            r_range_valid <= 1'b1;
          end
        end

        ST_DONE: begin
          r_done       <= 1'b0;
          r_mask_ready <= 1'b1;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_state       <= ST_IDLE;
          r_mask_ready  <= 1'b0;
          r_range_valid <= 1'b0;
          r_done        <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMASK_ENC_COUNT_EN
  logic [SRC_SIZE:0] r_range_count;

  // Runs emitted for the current mask; held in IDLE until the next accept.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_range_count <= {(SRC_SIZE+1){1'b0}};
    end else if (w_accept) begin
      r_range_count <= {(SRC_SIZE+1){1'b0}};
    end else if (w_range_hs) begin
      r_range_count <= r_range_count + PTR_ONE;
    end else begin
      r_range_count <= r_range_count;
    end
  end

  assign range_count = r_range_count;
`endif

  assign mask_ready  = r_mask_ready;
  assign range_valid = r_range_valid;
  assign C_start     = r_start;
  assign C_end       = r_end;
  assign done        = r_done;

endmodule

// File: tb/tb_cmask_range_encoder.sv
// Self-checking bench for cmask_range_encoder (default parameters).
// Expected runs come from a bit-walk reference model over the whole mask.
module tb_cmask_range_encoder;

  localparam int NC = 1024;

  logic          clock;
  logic          resetn;
  logic [NC-1:0] mask_in;
  logic          mask_valid;
  logic          mask_ready;
  logic [9:0]    C_start;
  logic [9:0]    C_end;
  logic          range_valid;
  logic          range_ready;
  logic          done;
`ifdef CMASK_ENC_COUNT_EN
  logic [10:0]   range_count;
`endif

  int tests = 0;
  int fails = 0;
  int qs[$];
  int qe[$];
  int exp_n;

  cmask_range_encoder dut (
    .clock       (clock),
    .resetn      (resetn),
    .mask_in     (mask_in),
    .mask_valid  (mask_valid),
    .mask_ready  (mask_ready),
    .C_start     (C_start),
    .C_end       (C_end),
    .range_valid (range_valid),
    .range_ready (range_ready),
`ifdef CMASK_ENC_COUNT_EN
    .range_count (range_count),
`endif
    .done        (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: list of maximal runs of 1s, lowest first.
  task automatic build_ref(input logic [NC-1:0] m);
    int s;
    qs.delete();
    qe.delete();
    s = -1;
    for (int i = 0; i < NC; i++) begin
      if (m[i] && s < 0) s = i;
      if (!m[i] && s >= 0) begin
        qs.push_back(s);
        qe.push_back(i - 1);
        s = -1;
      end
    end
    if (s >= 0) begin
      qs.push_back(s);
      qe.push_back(NC - 1);
    end
    exp_n = qs.size();
  endtask

  task automatic accept(input logic [NC-1:0] m);
    @(negedge clock);
    chk("ready_before_accept", 64'(mask_ready), 64'd1);
    mask_in    = m;
    mask_valid = 1'b1;
    @(posedge clock);
    #1;
    mask_valid = 1'b0;
    mask_in    = ~m;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mask_ready"}, 64'(mask_ready), 64'd0);
    chk({tag, "_range_valid"}, 64'(range_valid), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_c_start"}, 64'(C_start), 64'd0);
    chk({tag, "_c_end"}, 64'(C_end), 64'd0);
`ifdef CMASK_ENC_COUNT_EN
    chk({tag, "_count"}, 64'(range_count), 64'd0);
`endif
  endtask

  // mode 0: always ready; 1: random ready; 2: first run stalled 5 cycles
  // with mask_valid pulses. exp_first: 0 = unchecked, -1 = never valid.
  // exp_done: 0 = unchecked. Cycle numbers are relative to the accept edge.
  task automatic run_mask(input string tag, input logic [NC-1:0] m, input int mode,
                          input int exp_first, input int exp_done);
    int first, done_cyc, stall, nemit;
    logic have_prev, rdy;
    logic [9:0] p_s, p_e;
    build_ref(m);
    accept(m);
    first = -1; done_cyc = -1; stall = 0; nemit = 0; have_prev = 1'b0;
    for (int cyc = 1; cyc <= 5000 && done_cyc < 0; cyc++) begin
      @(negedge clock);
      if (have_prev) begin
        chk({tag, "_stall_valid"}, 64'(range_valid), 64'd1);
        chk({tag, "_stall_start"}, 64'(C_start), 64'(p_s));
        chk({tag, "_stall_end"}, 64'(C_end), 64'(p_e));
      end
      have_prev = 1'b0;
      chk({tag, "_ready_low"}, 64'(mask_ready), 64'd0);
      if (done) done_cyc = cyc;
      if (range_valid) begin
        if (first < 0) first = cyc;
        case (mode)
          1:       rdy = ($urandom_range(0, 2) != 0);
          2:       begin rdy = (stall >= 5); stall++; end
          default: rdy = 1'b1;
        endcase
        mask_valid  = (mode == 2) && !rdy;
        mask_in     = {32{$urandom}};
        range_ready = rdy;
        if (rdy) begin
          nemit++;
          if (qs.size() > 0) begin
            chk({tag, "_c_start"}, 64'(C_start), 64'(qs.pop_front()));
            chk({tag, "_c_end"}, 64'(C_end), 64'(qe.pop_front()));
          end else begin
            chk({tag, "_excess_range"}, 64'(nemit), 64'(exp_n));
          end
        end else begin
          have_prev = 1'b1;
          p_s = C_start;
          p_e = C_end;
        end
      end else begin
        mask_valid  = 1'b0;
        range_ready = 1'($urandom_range(0, 1));
      end
    end
    mask_valid = 1'b0;
    chk({tag, "_done_seen"}, 64'(done_cyc > 0), 64'd1);
    chk({tag, "_num_ranges"}, 64'(nemit), 64'(exp_n));
    if (exp_first == -1) chk({tag, "_no_valid"}, 64'(first), 64'(-1));
    if (exp_first > 0)   chk({tag, "_first_valid_cyc"}, 64'(first), 64'(exp_first));
    if (exp_done > 0)    chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
    @(negedge clock);
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, "_ready_after"}, 64'(mask_ready), 64'd1);
`ifdef CMASK_ENC_COUNT_EN
    chk({tag, "_count"}, 64'(range_count), 64'(exp_n));
`endif
    range_ready = 1'b0;
  endtask

  initial begin
    logic [NC-1:0] m;
    logic b;
    resetn      = 1'b1;
    mask_in     = '0;
    mask_valid  = 1'b0;
    range_ready = 1'b0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    resetn = 1'b1;
    #1 chk("ready_low_before_edge", 64'(mask_ready), 64'd0);
    @(negedge clock);
    chk("ready_after_reset", 64'(mask_ready), 64'd1);

    // bits 3..5
    m = '0;
    for (int i = 3; i <= 5; i++) m[i] = 1'b1;
    run_mask("bits3_5", m, 0, 3, 20);

    // all ones
    m = '1;
    run_mask("all_ones", m, 0, 18, 19);

    // zero mask
    m = '0;
    run_mask("zero", m, 0, -1, 17);

    // chunk-boundary merge plus last bit
    m = '0;
    for (int i = 60; i <= 70; i++) m[i] = 1'b1;
    m[100]  = 1'b1;
    m[1023] = 1'b1;
    run_mask("merge_last", m, 0, 4, 0);

    // stalled emit with ignored mask_valid pulses
    m = '0;
    for (int i = 200; i <= 210; i++) m[i] = 1'b1;
    for (int i = 300; i <= 330; i++) m[i] = 1'b1;
    run_mask("stall", m, 2, 0, 0);

    // reset during scan of bits 500..600
    m = '0;
    for (int i = 500; i <= 600; i++) m[i] = 1'b1;
    accept(m);
    repeat (5) @(negedge clock);
    resetn = 1'b0;
    #1 check_reset_outputs("midscan_reset");
    repeat (2) begin
      @(negedge clock);
      chk("midscan_no_done", 64'(done), 64'd0);
    end
    resetn = 1'b1;
    @(negedge clock);
    chk("midscan_ready_back", 64'(mask_ready), 64'd1);
    chk("midscan_no_valid", 64'(range_valid), 64'd0);
    m = '0;
    run_mask("after_reset_zero", m, 0, -1, 17);

    // random run patterns with random consumer back-pressure
    for (int t = 0; t < 8; t++) begin
      b = 1'($urandom_range(0, 1));
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 20) == 0) b = ~b;
        m[i] = b;
      end
      run_mask("random", m, 1, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
